// File: rtl/determ_pkg.sv
// Shared definitions for the deterministic bitstream encoders: state codes,
// derived sizes and the ones-count rounding/clamp helper.
package determ_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned DEF_BIT_WIDTH = 16;
    localparam int unsigned DEF_INT_WIDTH = 1;
    localparam int unsigned DEF_LOG_LEN   = 8;

    function automatic int unsigned stream_len(input int unsigned log_len);
        return 32'd1 << log_len;
    endfunction

    function automatic int unsigned frac_bits(input int unsigned bit_width,
                                              input int unsigned int_width);
        return bit_width - int_width;
    endfunction

    localparam int unsigned DEF_L = stream_len(DEF_LOG_LEN);
    localparam int unsigned DEF_F = frac_bits(DEF_BIT_WIDTH, DEF_INT_WIDTH);

    // Maps x (F fraction bits, sign-extended to 64) onto K ones out of 2^log_len:
    // offset into [0, 2^(F+1)], saturate, then scale with round-half-up.
    function automatic logic [31:0] ones_count(input logic signed [63:0] x,
                                               input int unsigned       frac,
                                               input int unsigned       log_len);
        logic signed [127:0] u;
        logic        [127:0] one_f;
        logic        [127:0] top;
        logic        [127:0] uc;
        one_f = 128'd1 << frac;
        top   = one_f << 1;
        u     = $signed({{64{x[63]}}, x}) + $signed(one_f);
        if (u[127])
            uc = '0;
        else if ($unsigned(u) > top)
            uc = top;
        else
            uc = $unsigned(u);
        return 32'(((uc << log_len) + one_f) >> (frac + 1));
    endfunction

endpackage

// File: rtl/determ_ones_calc.sv
// Combinational ones-count for one stream: K = round(L * (x + 1) / 2), saturated.
module determ_ones_calc
    import determ_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int unsigned INT_WIDTH = DEF_INT_WIDTH,
    parameter int unsigned LOG_LEN   = DEF_LOG_LEN
) (
    input  logic signed [BIT_WIDTH-1:0] x_in,
    output logic        [LOG_LEN:0]     k
);

    localparam int unsigned F = frac_bits(BIT_WIDTH, INT_WIDTH);

    logic signed [63:0] x_ext;

    assign x_ext = {{(64-BIT_WIDTH){x_in[BIT_WIDTH-1]}}, x_in};
    assign k     = (LOG_LEN+1)'(ones_count(x_ext, F, LOG_LEN));

endmodule

// File: rtl/determ_gen_fxp.sv
// Deterministic bipolar bitstream generator: emits L = 2^LOG_LEN bits per
// loaded value, with K ones spread by error diffusion; streams can be chained.
module determ_gen_fxp
    import determ_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int unsigned INT_WIDTH = DEF_INT_WIDTH,
    parameter int unsigned LOG_LEN   = DEF_LOG_LEN
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic signed [BIT_WIDTH-1:0] x_in,
    input  logic                        load,
    output logic                        ready,
    output logic                        bit_out,
    output logic                        valid,
    output logic                        last
);

    localparam logic [LOG_LEN:0] L_V = (LOG_LEN+1)'(stream_len(LOG_LEN));

    logic [0:0]         state;
    logic [LOG_LEN-1:0] cnt;
    logic [LOG_LEN-1:0] acc;
    logic [LOG_LEN:0]   k_r;
    logic [LOG_LEN:0]   k;
    logic [LOG_LEN:0]   s;
    logic [LOG_LEN:0]   s_wrap;
    logic               b;
    logic               cnt_last;
    logic               accept;

    determ_ones_calc #(
        .BIT_WIDTH (BIT_WIDTH),
        .INT_WIDTH (INT_WIDTH),
        .LOG_LEN   (LOG_LEN)
    ) u_ones (
        .x_in (x_in),
        .k    (k)
    );

    assign cnt_last = &cnt;
    assign ready    = (state == ST_IDLE) || (state == ST_RUN && cnt_last);
    assign accept   = load && ready;

    assign s      = {1'b0, acc} + k_r;
    assign b      = (s >= L_V);
    assign s_wrap = s - L_V;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            k_r     <= '0;
            bit_out <= 1'b0;
            valid   <= 1'b0;
            last    <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                bit_out <= b;
                valid   <= 1'b1;
                last    <= cnt_last;
                acc     <= b ? s_wrap[LOG_LEN-1:0] : s[LOG_LEN-1:0];
                cnt     <= cnt + 1'b1;
                if (cnt_last)
                    state <= ST_IDLE;
            end else begin
                bit_out <= 1'b0;
                valid   <= 1'b0;
                last    <= 1'b0;
            end
            // A load on the final RUN cycle overrides the return to IDLE,
            // while the outputs above still carry the old stream's last bit.
            if (accept) begin
                k_r   <= k;
                acc   <= '0;
                cnt   <= '0;
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_determ_gen_fxp.sv
// Scoreboard bench for determ_gen_fxp with L=8: one instance at INT_WIDTH=1,
// one at INT_WIDTH=2 for saturation.
module tb_determ_gen_fxp;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic signed [15:0] xa, xb;
    logic la, lb;
    logic ra, ba, va, lsa;
    logic rb, bb, vb, lsb;

    determ_gen_fxp #(.BIT_WIDTH(16), .INT_WIDTH(1), .LOG_LEN(3)) dut_a (
        .CLK(CLK), .nRST(nRST), .x_in(xa), .load(la),
        .ready(ra), .bit_out(ba), .valid(va), .last(lsa)
    );

    determ_gen_fxp #(.BIT_WIDTH(16), .INT_WIDTH(2), .LOG_LEN(3)) dut_b (
        .CLK(CLK), .nRST(nRST), .x_in(xb), .load(lb),
        .ready(rb), .bit_out(bb), .valid(vb), .last(lsb)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] q_a[$];
    logic [1:0] q_b[$];
    int run_a = 0, run_b = 0, last_run_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference K from real arithmetic: u = (x + 1) / 2 clamped to [0,1], K = floor(8u + 0.5).
    function automatic int k_model(input logic [15:0] x, input int intw);
        real xr, u;
        xr = $itor($signed(x)) / (2.0 ** (16 - intw));
        u  = (xr + 1.0) / 2.0;
        if (u < 0.0) u = 0.0;
        if (u > 1.0) u = 1.0;
        return $rtoi($floor(u * 8.0 + 0.5));
    endfunction

    // Evenly spread ones: bit i is set when floor((i+1)K/8) steps past floor(iK/8).
    task automatic push_stream(input int sel, input int k);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e;
            e[1] = (((i + 1) * k) / 8 - (i * k) / 8) != 0;
            e[0] = (i == 7);
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    task automatic send(input int sel, input logic [15:0] x);
        int t = 0;
        @(negedge CLK);
        while (!(sel != 0 ? rb : ra) && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (sel == 0) begin xa = x; la = 1'b1; end
        else          begin xb = x; lb = 1'b1; end
        @(posedge CLK);
        push_stream(sel, k_model(x, sel != 0 ? 2 : 1));
        #1;
        la = 1'b0;
        lb = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int t = 0;
        @(negedge CLK);
        while (t < 200 && ((sel == 0) ? (q_a.size() != 0 || va) : (q_b.size() != 0 || vb))) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check("idle_timeout", 32'd0, 32'd1);
        #1;
        check(sel == 0 ? "a_ready_idle" : "b_ready_idle", sel == 0 ? ra : rb, 32'd1);
        check(sel == 0 ? "a_valid_idle" : "b_valid_idle", sel == 0 ? va : vb, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (va) begin
            run_a++;
            if (q_a.size() == 0) check("a_extra_bit", 32'd1, 32'd0);
            else begin
                logic [1:0] e;
                e = q_a.pop_front();
                check("a_bit", ba, e[1]);
                check("a_last", lsa, e[0]);
            end
        end else begin
            if (run_a != 0) last_run_a = run_a;
            run_a = 0;
            check("a_last_idle", lsa, 32'd0);
        end
        if (vb) begin
            run_b++;
            if (q_b.size() == 0) check("b_extra_bit", 32'd1, 32'd0);
            else begin
                logic [1:0] e;
                e = q_b.pop_front();
                check("b_bit", bb, e[1]);
                check("b_last", lsb, e[0]);
            end
        end else begin
            run_b = 0;
            check("b_last_idle", lsb, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        xa = '0; xb = '0; la = 1'b0; lb = 1'b0;
        #12;
        check("rst_valid", va, 32'd0);
        check("rst_last", lsa, 32'd0);
        check("rst_bit", ba, 32'd0);
        check("rst_ready", ra, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        // zero input, with first-bit latency
        send(0, 16'h0000);
        @(negedge CLK);
        check("lat_before", va, 32'd0);
        @(negedge CLK);
        check("lat_first", va, 32'd1);
        wait_idle(0);

        // extremes and x = 0.25
        send(0, 16'h7FFF); wait_idle(0);
        send(0, 16'h8000); wait_idle(0);
        send(0, 16'h2000); wait_idle(0);

        // chained streams
        send(0, 16'h2000);
        send(0, 16'h0000);
        wait_idle(0);
        check("chain_run_len", last_run_a, 32'd16);

        // load while busy is ignored
        send(0, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("busy_ready", ra, 32'd0);
        xa = 16'h7FFF;
        la = 1'b1;
        @(posedge CLK);
        #1 la = 1'b0;
        wait_idle(0);

        // reset in the middle of a stream
        send(0, 16'h2000);
        repeat (6) @(negedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("mid_rst_valid", va, 32'd0);
        check("mid_rst_last", lsa, 32'd0);
        check("mid_rst_bit", ba, 32'd0);
        check("mid_rst_ready", ra, 32'd1);
        q_a.delete();
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (12) @(negedge CLK);
        #1;
        check("post_rst_ready", ra, 32'd1);

        // saturation on the INT_WIDTH=2 instance
        send(1, 16'h6000); wait_idle(1);
        send(1, 16'hA000); wait_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/determ_gen_fxp.md
# determ_gen_fxp

Deterministic bitstream generator. It converts one signed fixed-point value into a bipolar deterministic bitstream of fixed length L = 2^LOG_LEN (1 = +1, 0 = −1), with the ones spread evenly by error diffusion. It sits directly upstream of the deterministic FXP adder and drives that adder's single-bit operand. A `last` flag and a ready/load handshake allow streams to be chained back-to-back.

## Interface
- `BIT_WIDTH`, 16: width of the fixed-point input.
- `INT_WIDTH`, 1: integer bits of the input, sign included. Fraction bits F = BIT_WIDTH − INT_WIDTH.
- `LOG_LEN`, 8: log2 of the stream length L.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `x_in`  in  BIT_WIDTH, signed  value to encode; sampled only when `load && ready`.
- `load`  in  1  request to start a new stream with `x_in`.
- `ready`  out  1  the block accepts `load` this cycle (combinational from state and counter).
- `bit_out`  out  1  registered stream bit.
- `valid`  out  1  `bit_out` is a stream bit this cycle.
- `last`  out  1  `bit_out` is the final (L-th) bit of its stream.

## Operation
- **Ones count.**
  - u = x_in + 2^F, computed in F+2 bits and clamped to [0, 2^(F+1)]. Inputs outside [−1, +1] saturate.
  - K = (u·L + 2^F) >> (F+1): round half up, width LOG_LEN+1, range 0..L.
- **States.** IDLE and RUN. Registers: `state`, `cnt` (LOG_LEN bits), `acc` (LOG_LEN bits), `K_r` (LOG_LEN+1 bits), plus the output flops.
- **ready** = (state==IDLE) || (state==RUN && cnt==L−1).
- **Accepting a load.** On `load && ready`: K_r ← K, acc ← 0, cnt ← 0, state ← RUN. This applies in both IDLE and the final RUN cycle.
- **Each RUN cycle:**
  - s = acc + K_r.
  - b = (s ≥ L).
  - bit_out ← b; valid ← 1; last ← (cnt==L−1).
  - acc ← b ? s−L : s.
  - cnt ← cnt+1.
- **End of stream.** When cnt==L−1 and no load is accepted, state ← IDLE.
- **Outputs outside RUN.** In IDLE: valid ← 0, last ← 0, bit_out ← 0.
- **Ignored loads.** `load` while not ready is ignored; `x_in` is not sampled.
- **Guarantee.** Each stream contains exactly K ones in L bits. K=0 gives all zeros; K=L gives all ones.

## Timing
- **Reset values.** state=IDLE, cnt=0, acc=0, K_r=0, bit_out=0, valid=0, last=0. `ready`=1 while in reset.
- **Latency.** Load accepted at edge t0. The first `valid` bit appears after edge t0+1. The last bit appears after edge t0+L.
- **Back-to-back streams.** A load accepted during the cycle that computes bit L−1 gives zero gap: `valid` stays high across the boundary, and `last` pulses for exactly one cycle per stream.
- **Reset mid-stream.** All outputs drop to their reset values immediately (asynchronously). The partial stream is discarded and no `last` is emitted.
- **No backpressure.** The consumer must take one bit per cycle while `valid` is high.

## Structure
- **Shared package `determ_pkg`:**
  - state encoding (IDLE=0, RUN=1)
  - localparams for L and F derived from the parameters
  - ones-count rounding/clamp function, reused by any future deterministic encoder
- **Sub-module `determ_ones_calc`:** combinational, computes K from `x_in`. Parameters BIT_WIDTH, INT_WIDTH, LOG_LEN.
- **Top level:** the FSM, counter, diffusion accumulator and output registers.

## Test plan
Test plan uses BIT_WIDTH=16, INT_WIDTH=1, LOG_LEN=3 (L=8) unless stated.

1. **Zero input.** x_in=16'h0000, load one cycle → K=4. Bits 0,1,0,1,0,1,0,1; `last` on the 8th bit; `valid` drops next cycle; `ready` returns high.
2. **Full-scale extremes.** x_in=16'h7FFF → K=8, all eight bits 1. x_in=16'h8000 → K=0, all eight bits 0.
3. **x = 0.25.** x_in=16'h2000 → K=5. Bits 0,1,0,1,1,0,1,1.
4. **Chained streams.** Load 16'h2000, then load 16'h0000 in the cycle `ready` reasserts during RUN. `valid` is high for 16 consecutive cycles; `last` on bits 8 and 16; second stream is 0,1,0,1,0,1,0,1.
5. **Busy load and mid-stream reset.** Assert `load` with 16'h7FFF at bit 3 of a running 16'h0000 stream → ignored, first stream completes unchanged. Then assert `nRST`=0 at bit 5 of a new stream → valid, last and bit_out are 0 immediately; after release, `ready`=1 and no stray `last` appears.
6. **Saturation.** INT_WIDTH=2, x_in=16'h6000 (+1.5) → K=8, all ones. x_in=16'hA000 (−1.5) → all zeros.
